// File: rtl/router_fsm.sv
// Control FSM for the 3x1 router: decodes the header address, sequences the input
// register block and stalls the source. Optional WAIT_TILL_EMPTY timeout: ROUTER_FSM_TIMEOUT_EN.
module router_fsm #(
   parameter int WAIT_CYCLES = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [1:0] din,
   input  logic       fifo_full,
   input  logic [2:0] fifo_empty,
   input  logic [2:0] soft_reset,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic [1:0] sel_addr,
   output logic       write_enb_reg,
   output logic       detect_addr,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       busy,
   output logic       pkt_drop
);

   localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
   localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
   localparam logic [2:0] LOAD_DATA          = 3'd2;
   localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
   localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
   localparam logic [2:0] LOAD_PARITY        = 3'd5;
   localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
   localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

   logic [2:0] state_q, state_d;
   logic [1:0] sel_addr_q, sel_addr_d;
   logic       soft_rst_hit;
   logic       timeout;

   // Only the soft reset of the FIFO this packet targets can abort it.
   assign soft_rst_hit = (state_q != DECODE_ADDRESS) && soft_reset[sel_addr_q];

`ifdef ROUTER_FSM_TIMEOUT_EN
   localparam logic [4:0] CNT_LAST = 5'(WAIT_CYCLES - 1);
   logic [4:0] wait_cnt_q, wait_cnt_d;

   assign wait_cnt_d = (state_q == WAIT_TILL_EMPTY) ? wait_cnt_q + 5'd1 : 5'd0;
   assign timeout    = (state_q == WAIT_TILL_EMPTY) && (wait_cnt_q == CNT_LAST) &&
                       !fifo_empty[sel_addr_q];

   always_ff @(posedge clk) begin
      if (!rst) wait_cnt_q <= 5'd0;
      else      wait_cnt_q <= wait_cnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      sel_addr_d = sel_addr_q;
      if (soft_rst_hit) begin
         state_d = DECODE_ADDRESS;
      end else if (timeout) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (pkt_valid && (din != 2'b11)) begin
                  sel_addr_d = din;
                  state_d    = fifo_empty[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (parity_done)        state_d = DECODE_ADDRESS;
               else if (low_pkt_valid) state_d = LOAD_PARITY;
               else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: if (fifo_empty[sel_addr_q]) state_d = LOAD_FIRST_DATA;
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= DECODE_ADDRESS;
         sel_addr_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         sel_addr_q <= sel_addr_d;
      end
   end

   assign sel_addr      = sel_addr_q;
   assign detect_addr   = (state_q == DECODE_ADDRESS);
   assign lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign ld_state      = (state_q == LOAD_DATA);
   assign laf_state     = (state_q == LOAD_AFTER_FULL);
   assign full_state    = (state_q == FIFO_FULL_STATE);
   assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                          (state_q == LOAD_AFTER_FULL);
   assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
   // A soft reset outranks the timeout, so no drop is reported when it fires.
   assign pkt_drop      = timeout && !soft_rst_hit;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: packet-phase model checked every cycle plus directed literal checks.
module tb_router_fsm;

   localparam int WAIT_CYCLES = 30;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [1:0] din = 2'd0;
   logic       fifo_full = 1'b0;
   logic [2:0] fifo_empty = 3'b111;
   logic [2:0] soft_reset = 3'b000;
   logic       parity_done = 1'b0;
   logic       low_pkt_valid = 1'b0;
   logic [1:0] sel_addr;
   logic       write_enb_reg, detect_addr, lfd_state, ld_state, laf_state;
   logic       full_state, rst_int_reg, busy, pkt_drop;

   int tests_run = 0;
   int tests_failed = 0;

   router_fsm #(.WAIT_CYCLES(WAIT_CYCLES)) dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
      .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
      .sel_addr(sel_addr), .write_enb_reg(write_enb_reg), .detect_addr(detect_addr),
      .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy),
      .pkt_drop(pkt_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Packet-phase model: where the current packet is in its life.
   typedef enum int {P_IDLE, P_FIRST, P_BODY, P_STALL, P_RESUME, P_PAR, P_CHK, P_WAIT} phase_t;
   phase_t     m_ph = P_IDLE;
   logic [1:0] m_sel = 2'd0;
   int         m_wait_n = 0;
   bit         cmp_en = 1'b0;

   function automatic bit drop_exp();
`ifdef ROUTER_FSM_TIMEOUT_EN
      return (m_ph == P_WAIT) && (m_wait_n == WAIT_CYCLES) &&
             !fifo_empty[m_sel] && !soft_reset[m_sel];
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         m_ph <= P_IDLE;
         m_sel <= 2'd0;
         m_wait_n <= 0;
      end else if (m_ph != P_IDLE && soft_reset[m_sel]) begin
         m_ph <= P_IDLE;
      end else begin
         case (m_ph)
            P_IDLE: if (pkt_valid && din != 2'd3) begin
               m_sel <= din;
               if (fifo_empty[din]) m_ph <= P_FIRST;
               else begin m_ph <= P_WAIT; m_wait_n <= 1; end
            end
            P_FIRST:  m_ph <= P_BODY;
            P_BODY:   if (fifo_full) m_ph <= P_STALL; else if (!pkt_valid) m_ph <= P_PAR;
            P_STALL:  if (!fifo_full) m_ph <= P_RESUME;
            P_RESUME: m_ph <= parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
            P_PAR:    m_ph <= P_CHK;
            P_CHK:    m_ph <= fifo_full ? P_STALL : P_IDLE;
            P_WAIT: begin
               if (fifo_empty[m_sel]) m_ph <= P_FIRST;
               else if (drop_exp()) m_ph <= P_IDLE;
               else m_wait_n <= m_wait_n + 1;
            end
            default: m_ph <= P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_sel_addr", sel_addr, m_sel);
         chk("m_detect", detect_addr, m_ph == P_IDLE);
         chk("m_lfd", lfd_state, m_ph == P_FIRST);
         chk("m_ld", ld_state, m_ph == P_BODY);
         chk("m_laf", laf_state, m_ph == P_RESUME);
         chk("m_full", full_state, m_ph == P_STALL);
         chk("m_rst_int", rst_int_reg, m_ph == P_CHK);
         chk("m_we", write_enb_reg, m_ph inside {P_BODY, P_PAR, P_RESUME});
         chk("m_busy", busy, !(m_ph inside {P_IDLE, P_BODY}));
         chk("m_drop", pkt_drop, drop_exp());
      end
   end

   initial begin
      int fcnt;
      rst = 1'b0;
      tick();
      cmp_en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      tick();
      chk("reset_detect", detect_addr, 1);
      chk("reset_busy", busy, 0);
      chk("reset_sel", sel_addr, 0);
      chk("reset_we", write_enb_reg, 0);

      // Packet to FIFO1: LFD, 4x LD, LP, CPE, back to decode
      din = 2'd1; pkt_valid = 1'b1; fifo_empty = 3'b111;
      tick(); chk("p1_lfd", lfd_state, 1);
      tick(); chk("p1_ld", ld_state, 1);
      repeat (3) begin tick(); chk("p1_ld", ld_state, 1); end
      pkt_valid = 1'b0;
      tick(); chk("p1_lp_we", write_enb_reg, 1);
      tick(); chk("p1_cpe", rst_int_reg, 1);
      tick(); chk("p1_cpe_once", rst_int_reg, 0);
      chk("p1_decode", detect_addr, 1);
      chk("p1_sel", sel_addr, 1);

      // FIFO full for 3 cycles, then resume into parity
      din = 2'd0; pkt_valid = 1'b1;
      tick(); tick(); chk("p2_ld", ld_state, 1);
      fifo_full = 1'b1;
      fcnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         fcnt += int'(full_state);
         chk("p2_full_busy", busy, 1);
         chk("p2_full_we", write_enb_reg, 0);
      end
      fifo_full = 1'b0; low_pkt_valid = 1'b1; pkt_valid = 1'b0;
      tick(); chk("p2_laf", laf_state, 1); chk("p2_laf_we", write_enb_reg, 1);
      tick(); chk("p2_lp_we", write_enb_reg, 1); chk("p2_lp_busy", busy, 1);
      low_pkt_valid = 1'b0;
      tick(); chk("p2_cpe", rst_int_reg, 1);
      tick(); chk("p2_decode", detect_addr, 1);
      chk("p2_full_cycles", fcnt, 3);

      // FIFO2 not empty for 5 cycles
      din = 2'd2; fifo_empty = 3'b011; pkt_valid = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("p3_wait_busy", busy, 1);
         chk("p3_wait_no_lfd", lfd_state, 0);
         if (i < 4) tick();
      end
      fifo_empty = 3'b111;
      tick(); chk("p3_lfd", lfd_state, 1); chk("p3_sel", sel_addr, 2);
      tick(); chk("p3_ld", ld_state, 1);
      soft_reset = 3'b001;
      tick(); chk("p3_soft_other", ld_state, 1);
      soft_reset = 3'b100; pkt_valid = 1'b0;
      tick(); chk("p3_soft_own", detect_addr, 1);
      soft_reset = 3'b000;

      // Address 3 ignored
      din = 2'd3; pkt_valid = 1'b1;
      tick(); chk("p4_stay", detect_addr, 1); chk("p4_sel", sel_addr, 2);
      tick(); chk("p4_stay2", detect_addr, 1);

      // Wait on FIFO1 that never empties
      din = 2'd1; fifo_empty = 3'b101;
      tick(); chk("p5_wait", busy, 1);
`ifdef ROUTER_FSM_TIMEOUT_EN
      repeat (28) tick();
      chk("p5_no_drop_29", pkt_drop, 0);
      tick(); chk("p5_drop_30", pkt_drop, 1);
      pkt_valid = 1'b0;
      tick(); chk("p5_after_drop", detect_addr, 1); chk("p5_drop_once", pkt_drop, 0);
      din = 2'd0; fifo_empty = 3'b111; pkt_valid = 1'b1;
      tick(); chk("p5_lfd", lfd_state, 1);
`else
      repeat (40) tick();
      chk("p5_still_wait", busy, 1);
      chk("p5_no_detect", detect_addr, 0);
      chk("p5_no_drop", pkt_drop, 0);
      fifo_empty = 3'b111;
      tick(); chk("p5_lfd", lfd_state, 1);
`endif
      tick(); chk("p5_ld", ld_state, 1);
      rst = 1'b0;
      tick(); chk("rst_mid_detect", detect_addr, 1); chk("rst_mid_sel", sel_addr, 0);
      rst = 1'b1; pkt_valid = 1'b0;
      tick(); chk("rst_mid_idle", detect_addr, 1);

      // Full after parity check, resume with parity already captured
      din = 2'd0; pkt_valid = 1'b1;
      tick(); tick();
      pkt_valid = 1'b0;
      tick(); chk("p6_lp", write_enb_reg, 1);
      fifo_full = 1'b1;
      tick(); chk("p6_cpe", rst_int_reg, 1);
      tick(); chk("p6_full", full_state, 1);
      fifo_full = 1'b0; parity_done = 1'b1;
      tick(); chk("p6_laf", laf_state, 1);
      tick(); chk("p6_decode", detect_addr, 1);
      parity_done = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
